// File: rtl/fp_sqrt_arb_pkg.sv
// Shared types and constants for the square-root unit arbiter.
// Imported by the arbiter top and its round-robin picker.
package fp_sqrt_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } arb_state_e;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 64;

    // Counter only has to reach TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fp_sqrt_arbiter_picker.sv
// Round-robin priority picker: the search starts one past last_i
// and wraps, returning a one-hot grant and its binary index.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IW'((int'(last_i) + off) % N_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fp_sqrt_arbiter.sv
// Shares one square-root unit between N_REQ requesters, one
// operation in flight, with a per-operation watchdog.
module fp_sqrt_arbiter
    import fp_sqrt_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_d,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    resp_valid,
    input  logic [N_REQ-1:0]    resp_ready,
    output logic [31:0]         resp_q,
    output logic                resp_err,
    output logic [31:0]         sqrt_d,
    output logic                sqrt_start,
    input  logic                sqrt_busy,
    input  logic                sqrt_ready,
    input  logic [31:0]         sqrt_q
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cnt_width(TIMEOUT);

    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic [31:0]   op_q, op_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   res_q, res_d;
    logic          err_q, err_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [31:0]      ops [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_ops
        assign ops[i] = req_d[32*i +: 32];
    end

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign sqrt_d  = op_q;
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        id_d       = id_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        err_d      = err_q;
        req_ready  = '0;
        resp_valid = '0;
        resp_q     = '0;
        resp_err   = 1'b0;
        sqrt_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A busy unit may still be draining a timed-out op.
                if (!reset && !sqrt_busy && pick_any) begin
                    req_ready = pick_gnt;
                    op_d      = ops[pick_idx];
                    id_d      = pick_idx;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sqrt_start = 1'b1;
                cnt_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (sqrt_ready) begin
                    res_d   = sqrt_q;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_inc == CNT_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid[id_q] = 1'b1;
                resp_q           = res_q;
                resp_err         = err_q;
                if (resp_ready[id_q]) begin
                    last_d  = id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            id_q    <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Directed bench for fp_sqrt_arbiter with a latency-programmable
// square-root unit model answering from a small result table.
module tb_fp_sqrt_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_d = '0;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready = '0;
    logic [31:0]  resp_q;
    logic         resp_err;
    logic [31:0]  sqrt_d;
    logic         sqrt_start;
    logic         sqrt_busy;
    logic         sqrt_ready;
    logic [31:0]  sqrt_q;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int          model_lat = 3;
    bit          model_en = 1'b1;
    bit          busy_force = 1'b0;
    bit          stray = 1'b0;
    bit          pend = 1'b0;
    bit          m_rdy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_q = '0;

    assign sqrt_busy  = pend | busy_force;
    assign sqrt_ready = m_rdy | stray;
    assign sqrt_q     = m_q;

    fp_sqrt_arbiter #(
        .N_REQ   (4),
        .TIMEOUT (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_d      (req_d),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_q     (resp_q),
        .resp_err   (resp_err),
        .sqrt_d     (sqrt_d),
        .sqrt_start (sqrt_start),
        .sqrt_busy  (sqrt_busy),
        .sqrt_ready (sqrt_ready),
        .sqrt_q     (sqrt_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] ref_sqrt(input logic [31:0] d);
        case (d)
            32'h40800000: return 32'h40000000;
            32'h40000000: return 32'h3FB504F3;
            32'h41100000: return 32'h40400000;
            32'h3F800000: return 32'h3F800000;
            default:      return 32'h00000000;
        endcase
    endfunction

    always @(negedge clock) begin
        m_rdy = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    pend  = 1'b0;
                    m_rdy = 1'b1;
                    m_q   = m_res;
                end
            end
            if (sqrt_start && model_en) begin
                pend  = 1'b1;
                m_cnt = model_lat;
                m_res = ref_sqrt(sqrt_d);
            end
        end
    end

    task automatic wait_resp(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            resp_ready = '0;
            #1;
            if (resp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_grant(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            #1;
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            resp_ready = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        req_valid  = '0;
        req_d      = '0;
        resp_ready = '0;
        busy_force = 1'b0;
        stray      = 1'b0;
        model_en   = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 4'hF;
        repeat (2) @(negedge clock);
        #1;
        n_vec++;
        if (req_ready !== 4'b0 || resp_valid !== 4'b0 || resp_q !== 32'h0 ||
            resp_err !== 1'b0 || sqrt_start !== 1'b0 || sqrt_d !== 32'h0) begin
            n_err++;
            $display("FAIL reset: rdy=%b rv=%b q=%h err=%b st=%b d=%h expected all 0",
                     req_ready, resp_valid, resp_q, resp_err, sqrt_start, sqrt_d);
        end
        req_valid = '0;
        reset     = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int g;
        do_reset();
        model_lat = 3;
        @(negedge clock);
        req_d[31:0] = 32'h40800000;
        req_valid   = 4'b0001;
        #1;
        g = cyc;
        n_vec++;
        if (req_ready !== 4'b0001 || sqrt_start !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant: req_ready=%b start=%b expected 0001/0",
                     req_ready, sqrt_start);
        end
        @(negedge clock);
        req_valid = '0;
        #1;
        n_vec++;
        if (sqrt_start !== 1'b1 || sqrt_d !== 32'h40800000 || req_ready !== 4'b0) begin
            n_err++;
            $display("FAIL single_start: start=%b d=%h rdy=%b expected 1/40800000/0000",
                     sqrt_start, sqrt_d, req_ready);
        end
        wait_resp(20, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL single_resp: timeout got resp_valid=0000 expected 0001");
        end else if (cyc - g != 5 || resp_valid !== 4'b0001 ||
                     resp_q !== 32'h40000000 || resp_err !== 1'b0) begin
            n_err++;
            $display("FAIL single_resp: cyc=%0d rv=%b q=%h err=%b expected 5/0001/40000000/0",
                     cyc - g, resp_valid, resp_q, resp_err);
        end
        resp_ready = 4'b0001;
        @(negedge clock);
        resp_ready = '0;
        #1;
        n_vec++;
        if (resp_valid !== 4'b0) begin
            n_err++;
            $display("FAIL single_consume: resp_valid=%b expected 0000", resp_valid);
        end
    endtask

    task automatic test_fairness();
        bit          ok;
        int          prev_g;
        int          idx;
        logic [3:0]  eb;
        logic [31:0] exp_q [4];
        exp_q = '{32'h3FB504F3, 32'h40400000, 32'h3F800000, 32'h40000000};
        do_reset();
        model_lat = 3;
        prev_g    = -1;
        req_d     = {32'h40800000, 32'h3F800000, 32'h41100000, 32'h40000000};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            idx = k % 4;
            eb  = 4'b0001 << idx;
            wait_grant(30, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL rr_grant%0d: timeout got req_ready=0000 expected %b", k, eb);
            end else if (req_ready !== eb ||
                         (prev_g >= 0 && cyc - prev_g != 6)) begin
                n_err++;
                $display("FAIL rr_grant%0d: req_ready=%b gap=%0d expected %b gap 6",
                         k, req_ready, cyc - prev_g, eb);
            end
            prev_g = cyc;
            wait_resp(30, ok);
            n_vec++;
            if (!ok || resp_valid !== eb || resp_q !== exp_q[idx] || resp_err !== 1'b0) begin
                n_err++;
                $display("FAIL rr_resp%0d: rv=%b q=%h err=%b expected %b/%h/0",
                         k, resp_valid, resp_q, resp_err, eb, exp_q[idx]);
            end
            resp_ready = resp_valid;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        model_lat = 3;
        @(negedge clock);
        req_d[95:64] = 32'h41100000;
        req_valid    = 4'b0100;
        #1;
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL bp_grant: req_ready=%b expected 0100", req_ready);
        end
        @(negedge clock);
        req_valid = 4'hF;
        wait_resp(20, ok);
        n_vec++;
        if (!ok || resp_valid !== 4'b0100) begin
            n_err++;
            $display("FAIL bp_resp: resp_valid=%b expected 0100", resp_valid);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            resp_ready = 4'b1011;
            #1;
            n_vec++;
            if (resp_valid !== 4'b0100 || resp_q !== 32'h40400000 ||
                req_ready !== 4'b0 || sqrt_start !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: rv=%b q=%h rdy=%b st=%b expected 0100/40400000/0000/0",
                         i, resp_valid, resp_q, req_ready, sqrt_start);
            end
        end
        @(negedge clock);
        resp_ready = 4'b0100;
        @(negedge clock);
        resp_ready = '0;
        #1;
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL bp_next_grant: req_ready=%b expected 1000", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_watchdog();
        bit ok;
        int g;
        do_reset();
        model_en = 1'b0;
        @(negedge clock);
        req_d[31:0] = 32'h40800000;
        req_valid   = 4'b0001;
        #1;
        g = cyc;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL wd_grant: req_ready=%b expected 0001", req_ready);
        end
        @(negedge clock);
        req_valid  = '0;
        busy_force = 1'b1;
        wait_resp(20, ok);
        n_vec++;
        if (!ok || cyc - g != 9 || resp_valid !== 4'b0001 ||
            resp_err !== 1'b1 || resp_q !== 32'h0) begin
            n_err++;
            $display("FAIL wd_resp: cyc=%0d rv=%b err=%b q=%h expected 9/0001/1/0",
                     cyc - g, resp_valid, resp_err, resp_q);
        end
        resp_ready = 4'b0001;
        req_valid  = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            resp_ready = '0;
            #1;
            n_vec++;
            if (req_ready !== 4'b0 || resp_valid !== 4'b0) begin
                n_err++;
                $display("FAIL wd_busy%0d: rdy=%b rv=%b expected 0000/0000",
                         i, req_ready, resp_valid);
            end
        end
        @(negedge clock);
        busy_force = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL wd_release: req_ready=%b expected 0010", req_ready);
        end
        req_valid = '0;
        model_en  = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        model_lat = 7;
        @(negedge clock);
        req_d[31:0] = 32'h40800000;
        req_valid   = 4'b0001;
        @(negedge clock);
        req_valid = '0;
        #1;
        n_vec++;
        if (sqrt_start !== 1'b1) begin
            n_err++;
            $display("FAIL rm_start: sqrt_start=%b expected 1", sqrt_start);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        n_vec++;
        if (req_ready !== 4'b0 || resp_valid !== 4'b0 || resp_q !== 32'h0 ||
            resp_err !== 1'b0 || sqrt_start !== 1'b0 || sqrt_d !== 32'h0) begin
            n_err++;
            $display("FAIL rm_outputs: rdy=%b rv=%b q=%h err=%b st=%b d=%h expected all 0",
                     req_ready, resp_valid, resp_q, resp_err, sqrt_start, sqrt_d);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            stray = (i == 2);
            #1;
            n_vec++;
            if (resp_valid !== 4'b0 || sqrt_start !== 1'b0) begin
                n_err++;
                $display("FAIL rm_quiet%0d: rv=%b st=%b expected 0000/0",
                         i, resp_valid, sqrt_start);
            end
        end
        stray = 1'b0;
        @(negedge clock);
        req_valid = 4'hF;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL rm_priority: req_ready=%b expected 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_coincide();
        bit ok;
        int g;
        for (int lat = 7; lat <= 8; lat++) begin
            do_reset();
            model_lat = lat;
            @(negedge clock);
            req_d[31:0] = 32'h40800000;
            req_valid   = 4'b0001;
            #1;
            g = cyc;
            @(negedge clock);
            req_valid = '0;
            wait_resp(20, ok);
            n_vec++;
            if (lat == 7 && (!ok || cyc - g != 9 || resp_valid !== 4'b0001 ||
                             resp_err !== 1'b0 || resp_q !== 32'h40000000)) begin
                n_err++;
                $display("FAIL coincide: cyc=%0d rv=%b err=%b q=%h expected 9/0001/0/40000000",
                         cyc - g, resp_valid, resp_err, resp_q);
            end else if (lat == 8 && (!ok || cyc - g != 9 || resp_valid !== 4'b0001 ||
                                      resp_err !== 1'b1 || resp_q !== 32'h0)) begin
                n_err++;
                $display("FAIL late_ready: cyc=%0d rv=%b err=%b q=%h expected 9/0001/1/0",
                         cyc - g, resp_valid, resp_err, resp_q);
            end
            resp_ready = 4'b0001;
            @(negedge clock);
            resp_ready = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_reset_mid();
        test_coincide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
